// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the async FIFO: drains burst_len words through a 2-entry skid buffer
// onto a valid/ready stream. Optional FIFO_RD_STATS_EN adds a saturating word_cnt output.
module fifo_burst_reader #(
  parameter int DW    = 16,
  parameter int LEN_W = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             fifo_rd,
  input  logic [DW-1:0]    fifo_rdata,
  input  logic             fifo_rempty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       dbg_state
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  // Stream handshake: a word transfers on a rising edge where out_valid and out_ready are both 1;
  // once raised, out_valid and out_data stay fixed until that transfer happens.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] issue_rem;
  logic [LEN_W-1:0] deliver_rem;
  logic             inflight;
  logic [1:0]       occ;
  logic [DW-1:0]    buf0;
  logic [DW-1:0]    buf1;
  logic             pop;
  logic             accept;
  logic [2:0]       fill;

  assign busy      = (state == S_READ);
  assign done      = (state == S_DONE);
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0;
  assign dbg_state = state;
  assign pop       = out_valid & out_ready;
  assign accept    = (state == S_IDLE) & start;

  // Words the buffer will hold after this edge, before counting a new read; crediting the pop
  // lets a read issue every cycle while downstream keeps accepting.
  assign fill    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd = (state == S_READ) & ~fifo_rempty & (issue_rem != '0) & (fill < 3'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (burst_len == '0) ? S_DONE : S_READ;
      S_READ: if (pop && (deliver_rem == LEN_W'(1))) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      issue_rem   <= '0;
      deliver_rem <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (accept) begin
        issue_rem   <= burst_len;
        deliver_rem <= burst_len;
      end else begin
        if (fifo_rd) issue_rem <= issue_rem - LEN_W'(1);
        if (pop) deliver_rem <= deliver_rem - LEN_W'(1);
      end
    end
  end

  // buf0 is always the head; the FIFO's read data lands one cycle after fifo_rd.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_rdata;
          else             buf1 <= fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      word_cnt <= '0;
    end else if (pop && (word_cnt != 32'hFFFF_FFFF)) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a FIFO model feeds the DUT; the expected stream is simply every
// word written to the FIFO, in write order, minus words lost to a reset.
module tb_fifo_burst_reader;
  localparam int DW    = 16;
  localparam int LEN_W = 8;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             busy, done, fifo_rd;
  logic [DW-1:0]    fifo_rdata = '0;
  logic             fifo_rempty;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic [1:0]       dbg_state;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]      word_cnt;
`endif

  fifo_burst_reader #(.DW(DW), .LEN_W(LEN_W)) dut (
    .rclk(rclk), .rrst(rrst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata),
    .fifo_rempty(fifo_rempty), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .dbg_state(dbg_state)
`ifdef FIFO_RD_STATS_EN
    , .word_cnt(word_cnt)
`endif
  );

  // ---------------- clock / reset
  always #5 rclk = ~rclk;

  // ---------------- FIFO model (1-cycle read latency)
  logic [DW-1:0] mem [64];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rd_pulses = 0;
  assign fifo_rempty = (wr_cnt == rd_cnt);

  always @(posedge rclk) begin
    if (fifo_rd) begin
      rd_pulses <= rd_pulses + 1;
      if (!fifo_rempty) begin
        fifo_rdata <= mem[rd_cnt % 64];
        rd_cnt     <= rd_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int delivered = 0;
  int pops_model = 0;
  logic hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rclk) begin
    if (rrst) begin
      // Words already pulled out of the FIFO but not delivered are lost to reset.
      while (exp_q.size() > (wr_cnt - rd_cnt)) void'(exp_q.pop_front());
      pops_model = 0;
      hold_v = 1'b0;
    end else begin
      if (fifo_rd) chk("rd_while_empty", 32'(fifo_rempty), 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected no word at %0t", out_data, $time);
        end else begin
          chk("stream_data", 32'(out_data), 32'(exp_q[0]));
        end
      end
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
      end
`ifdef FIFO_RD_STATS_EN
      chk("word_cnt", word_cnt, 32'(pops_model));
`endif
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        delivered++;
        pops_model++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  // ---------------- driver tasks
  task automatic fifo_write(input logic [DW-1:0] w);
    mem[wr_cnt % 64] = w;
    wr_cnt++;
    exp_q.push_back(w);
  endtask

  task automatic start_burst(input int len);
    @(negedge rclk);
    start = 1'b1;
    burst_len = LEN_W'(len);
    @(negedge rclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge rclk);
      cyc++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
  endtask

  task automatic wait_delivered(input int target, input int limit);
    int n = 0;
    while (delivered < target && n < limit) begin
      @(negedge rclk);
      n++;
    end
    #1;
    chk("delivered_reach", 32'(delivered), 32'(target));
  endtask

  // ---------------- directed tests
  int cyc, rd0, dn0, dl0;

  initial begin
    // reset state
    repeat (3) @(negedge rclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rrst = 1'b0;

    // burst_len = 0: done the cycle after start, no read, never busy
    out_ready = 1'b1;
    rd0 = rd_pulses;
    @(negedge rclk);
    start = 1'b1;
    burst_len = '0;
    #1 chk("len0_busy_pre", 32'(busy), 32'd0);
    @(negedge rclk);
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    @(negedge rclk);
    chk("len0_done_off", 32'(done), 32'd0);
    chk("len0_busy2", 32'(busy), 32'd0);
    chk("len0_rd", 32'(rd_pulses - rd0), 32'd0);

    // reset mid-burst after 3 words popped, then burst of 5 reads words 4..8
    for (int i = 1; i <= 3; i++) fifo_write(DW'(i));
    start_burst(8);
    wait_delivered(3, 20);
    repeat (2) @(negedge rclk);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_rd", 32'(fifo_rd), 32'd0);
    rrst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_rd", 32'(fifo_rd), 32'd0);
    @(negedge rclk);
    rrst = 1'b0;
    for (int i = 4; i <= 8; i++) fifo_write(DW'(i));
    dn0 = done_cnt;
    dl0 = delivered;
    start_burst(5);
    wait_done(40, cyc);
    #1;
    chk("rst_burst_words", 32'(delivered - dl0), 32'd5);
    chk("rst_burst_done", 32'(done_cnt - dn0), 32'd1);

    // preload 1..8, burst of 8, out_ready=1
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    rd0 = rd_pulses;
    dn0 = done_cnt;
    start_burst(8);
    @(negedge rclk);
    chk("lat_valid_k1", 32'(out_valid), 32'd0);
    @(negedge rclk);
    chk("lat_valid_k2", 32'(out_valid), 32'd1);
    chk("first_word", 32'(out_data), 32'd1);
    wait_done(40, cyc);
    chk("done_cycle", 32'(cyc), 32'd8);
    @(negedge rclk);
    #1;
    chk("b8_done_cnt", 32'(done_cnt - dn0), 32'd1);
    chk("b8_rd_pulses", 32'(rd_pulses - rd0), 32'd8);
    chk("b8_busy_after", 32'(busy), 32'd0);
`ifdef FIFO_RD_STATS_EN
    chk("word_cnt_13", word_cnt, 32'd13);
`endif

    // backpressure: out_ready low 5 cycles, two reads then stall with word 1 held
    for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
    out_ready = 1'b0;
    rd0 = rd_pulses;
    dl0 = delivered;
    start_burst(8);
    repeat (5) @(negedge rclk);
    chk("bp_rd_pulses", 32'(rd_pulses - rd0), 32'd2);
    chk("bp_head", 32'(out_data), 32'd1);
    chk("bp_rd_low", 32'(fifo_rd), 32'd0);
    out_ready = 1'b1;
    wait_done(40, cyc);
    #1;
    chk("bp_words", 32'(delivered - dl0), 32'd8);
    chk("bp_rd_total", 32'(rd_pulses - rd0), 32'd8);
    chk("bp_exp_empty", 32'(exp_q.size()), 32'd0);

    // empty FIFO at start, two words trickle in 10 cycles apart
    rd0 = rd_pulses;
    dn0 = done_cnt;
    start_burst(2);
    repeat (3) @(negedge rclk);
    chk("empty_rd_none", 32'(rd_pulses - rd0), 32'd0);
    fifo_write(16'hA5A5);
    repeat (10) @(negedge rclk);
    fifo_write(16'h5A5A);
    wait_done(40, cyc);
    #1;
    chk("trickle_rd", 32'(rd_pulses - rd0), 32'd2);
    chk("trickle_done", 32'(done_cnt - dn0), 32'd1);

    // start pulsed while busy is ignored
    for (int i = 0; i < 6; i++) fifo_write(DW'(16'h100 + i));
    rd0 = rd_pulses;
    dn0 = done_cnt;
    dl0 = delivered;
    start_burst(4);
    start = 1'b1;
    burst_len = LEN_W'(7);
    @(negedge rclk);
    start = 1'b0;
    wait_done(40, cyc);
    repeat (4) @(negedge rclk);
    #1;
    chk("busy_start_words", 32'(delivered - dl0), 32'd4);
    chk("busy_start_done", 32'(done_cnt - dn0), 32'd1);
    chk("busy_start_rd", 32'(rd_pulses - rd0), 32'd4);
    chk("busy_start_left", 32'(wr_cnt - rd_cnt), 32'd2);
    start_burst(2);
    wait_done(40, cyc);
    @(negedge rclk);
    #1;
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
